attack_input_arbiter: RTL and testbench
=======================================

Name: attack_input_arbiter

Overview:
- Upstream of the battle engine: converts raw PS/2 scan-code bytes from the keyboard receiver into turn-ordered attack commands.
- Filters break and extended sequences and enforces player/enemy alternation.
- Rejects weapon picks that have no uses left and auto-selects Punch on turn timeout.
- Drives player_choice/enemy_choice and the turn flags consumed by the engine; advances turns on the engine's collision_detected.

Parameters:
- TIMEOUT_CYCLES, 32'd500_000_000, cycles allowed per turn before auto-Punch (0 disables timeout)
- KEY_PP/PK/PB/PS, 8'h1C/8'h1B/8'h23/8'h1D, player Punch/Kick/Bat/Sword make codes
- KEY_EP/EK/EB/ES, 8'h3B/8'h42/8'h4B/8'h43, enemy Punch/Kick/Bat/Sword make codes

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- scan_code  in  8  byte from PS/2 receiver
- scan_valid  in  1  one-cycle strobe, scan_code valid
- battle_start  in  1  pulse, begin battle
- battle_end  in  1  player_win | enemy_win from engine
- collision_detected  in  1  engine finished resolving current attack
- player_remained_sword / player_remained_baseballbat  in  1 each  player weapon has uses left
- enemy_remained_sword / enemy_remained_baseballbat  in  1 each  enemy weapon has uses left
- player_choice  out  2  00 Punch, 01 Kick, 10 Bat, 11 Sword
- enemy_choice  out  2  same encoding
- player_turn  out  1  player may/does attack
- enemy_turn  out  1  enemy may/does attack
- attack_valid  out  1  one-cycle pulse, choice for current turn is committed
- key_reject  out  1  one-cycle pulse, selected weapon exhausted
- timeout_pulse  out  1  one-cycle pulse, auto-Punch issued

Behaviour:
- Reset values: all outputs 0; state IDLE; prefix flags and timer cleared. Reset mid-operation aborts the pending attack with no attack_valid.
- Prefix filter, active in every state:
  - Byte F0 sets brk. The next byte is discarded and clears brk.
  - Byte E0 sets ext. The next byte is discarded and clears ext.
  - Only plain make codes reach the FSM.
- FSM states: IDLE, P_SELECT, P_RESOLVE, E_SELECT, E_RESOLVE.
- IDLE: turn flags 0. On battle_start go to P_SELECT.
- P_SELECT:
  - player_turn=1; timer counts up.
  - A valid player make code latches player_choice, pulses attack_valid next cycle, and moves to P_RESOLVE.
  - Bat with player_remained_baseballbat=0, or Sword with player_remained_sword=0: pulse key_reject, stay, timer not reset.
  - Enemy codes and unknown codes are ignored.
  - Timer reaching TIMEOUT_CYCLES-1: player_choice=00, attack_valid and timeout_pulse together, go to P_RESOLVE.
- P_RESOLVE: player_turn stays 1; all keys ignored. On collision_detected go to E_SELECT and clear the timer.
- E_SELECT / E_RESOLVE: mirror of the player states using enemy codes and flags; collision_detected returns to P_SELECT.
- Choice latency: attack_valid asserts exactly 1 cycle after the accepted scan_valid. Choice registers hold their value until the next accepted key for that side.
- player_turn and enemy_turn are never both 1.
- Priority:
  - battle_end in any non-IDLE state goes to IDLE (beats simultaneous collision_detected or key).
  - battle_start while not IDLE is ignored.
  - collision_detected in a SELECT state is ignored.
- A key accepted on the same cycle as the timeout: the key wins and timeout_pulse is not raised.
- Timer width: 32 bits, saturating; it never wraps.

Decomposition:
- Shared package: choice encoding constants (PUNCH/KICK/BAT/SWORD), the eight key-code constants, and the F0/E0 prefix constants. The top-level decode case reuses the same constants.
- Sub-module ps2_prefix_filter: holds the brk/ext flags and emits make_code plus make_valid. The arbiter FSM instantiates it once.

Test Plan:
- Reset, battle_start, scan 1C → player_turn=1, then player_choice=00 and attack_valid pulse 1 cycle after scan_valid; state P_RESOLVE.
- In P_SELECT, scan F0 then 1D → no attack_valid; then scan 1D with player_remained_sword=1 → player_choice=11, attack_valid.
- In P_SELECT, scan 23 with player_remained_baseballbat=0 → key_reject pulse, no attack_valid, player_turn stays 1.
- collision_detected in P_RESOLVE → enemy_turn=1, player_turn=0. Then scan 1C (player key) ignored; scan 42 → enemy_choice=01, attack_valid.
- TIMEOUT_CYCLES=16, no key → attack_valid + timeout_pulse on cycle 16 of E_SELECT, enemy_choice=00.
- In P_RESOLVE, battle_end and collision_detected same cycle → IDLE, both turn flags 0. rst asserted in E_SELECT → all outputs 0 next cycle.

Source files
------------

// File: rtl/attack_input_arbiter_pkg.sv
// Shared constants for the attack input arbiter: choice encoding, PS/2 key codes,
// scan-code prefixes and the arbiter FSM state type.
package attack_input_arbiter_pkg;

  localparam logic [1:0] PUNCH = 2'b00;
  localparam logic [1:0] KICK  = 2'b01;
  localparam logic [1:0] BAT   = 2'b10;
  localparam logic [1:0] SWORD = 2'b11;

  localparam logic [7:0] SCAN_PP = 8'h1C;
  localparam logic [7:0] SCAN_PK = 8'h1B;
  localparam logic [7:0] SCAN_PB = 8'h23;
  localparam logic [7:0] SCAN_PS = 8'h1D;
  localparam logic [7:0] SCAN_EP = 8'h3B;
  localparam logic [7:0] SCAN_EK = 8'h42;
  localparam logic [7:0] SCAN_EB = 8'h4B;
  localparam logic [7:0] SCAN_ES = 8'h43;

  localparam logic [7:0] PREFIX_BREAK = 8'hF0;
  localparam logic [7:0] PREFIX_EXT   = 8'hE0;

  typedef enum logic [2:0] {
    IDLE,
    P_SELECT,
    P_RESOLVE,
    E_SELECT,
    E_RESOLVE
  } arb_state_t;

endpackage

// File: rtl/attack_input_arbiter_prefix_filter.sv
// PS/2 prefix filter: swallows F0 (break) and E0 (extended) prefixes together with
// the byte that follows each, passing only plain make codes downstream.
module ps2_prefix_filter
  import attack_input_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] make_code,
  output logic       make_valid
);

  logic brk;
  logic ext;

  // Combinational pass-through so an accepted make code costs no extra cycle.
  assign make_code  = scan_code;
  assign make_valid = scan_valid && !brk && !ext &&
                      (scan_code != PREFIX_BREAK) && (scan_code != PREFIX_EXT);

  always_ff @(posedge clk) begin
    if (rst) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (scan_valid) begin
      if (brk || ext) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (scan_code == PREFIX_BREAK) begin
        brk <= 1'b1;
      end else if (scan_code == PREFIX_EXT) begin
        ext <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/attack_input_arbiter.sv
// Turn arbiter: converts filtered make codes into alternating player/enemy attack
// commands, rejecting exhausted weapons and auto-punching on turn timeout.
module attack_input_arbiter
  import attack_input_arbiter_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000,
  parameter logic [7:0]  KEY_PP = SCAN_PP,
  parameter logic [7:0]  KEY_PK = SCAN_PK,
  parameter logic [7:0]  KEY_PB = SCAN_PB,
  parameter logic [7:0]  KEY_PS = SCAN_PS,
  parameter logic [7:0]  KEY_EP = SCAN_EP,
  parameter logic [7:0]  KEY_EK = SCAN_EK,
  parameter logic [7:0]  KEY_EB = SCAN_EB,
  parameter logic [7:0]  KEY_ES = SCAN_ES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       battle_start,
  input  logic       battle_end,
  input  logic       collision_detected,
  input  logic       player_remained_sword,
  input  logic       player_remained_baseballbat,
  input  logic       enemy_remained_sword,
  input  logic       enemy_remained_baseballbat,
  output logic [1:0] player_choice,
  output logic [1:0] enemy_choice,
  output logic       player_turn,
  output logic       enemy_turn,
  output logic       attack_valid,
  output logic       key_reject,
  output logic       timeout_pulse
);

  arb_state_t  state;
  logic [31:0] timer;
  logic [31:0] timer_next;
  logic [7:0]  make_code;
  logic        make_valid;
  logic        p_hit, e_hit;
  logic [1:0]  p_sel, e_sel;
  logic        p_blocked, e_blocked;
  logic        timeout_hit;

  ps2_prefix_filter u_filter (
    .clk        (clk),
    .rst        (rst),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .make_code  (make_code),
    .make_valid (make_valid)
  );

  always_comb begin
    p_hit = 1'b0;
    p_sel = PUNCH;
    e_hit = 1'b0;
    e_sel = PUNCH;
    case (make_code)
      KEY_PP: begin p_hit = 1'b1; p_sel = PUNCH; end
      KEY_PK: begin p_hit = 1'b1; p_sel = KICK;  end
      KEY_PB: begin p_hit = 1'b1; p_sel = BAT;   end
      KEY_PS: begin p_hit = 1'b1; p_sel = SWORD; end
      KEY_EP: begin e_hit = 1'b1; e_sel = PUNCH; end
      KEY_EK: begin e_hit = 1'b1; e_sel = KICK;  end
      KEY_EB: begin e_hit = 1'b1; e_sel = BAT;   end
      KEY_ES: begin e_hit = 1'b1; e_sel = SWORD; end
      default: ;
    endcase
  end

  assign p_blocked = ((p_sel == BAT) && !player_remained_baseballbat) ||
                     ((p_sel == SWORD) && !player_remained_sword);
  assign e_blocked = ((e_sel == BAT) && !enemy_remained_baseballbat) ||
                     ((e_sel == SWORD) && !enemy_remained_sword);

  // A zero timeout disables auto-punch; the timer saturates rather than wrapping.
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (timer == TIMEOUT_CYCLES - 32'd1);
  assign timer_next  = (timer == 32'hFFFF_FFFF) ? timer : timer + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= 32'd0;
      player_choice <= PUNCH;
      enemy_choice  <= PUNCH;
      player_turn   <= 1'b0;
      enemy_turn    <= 1'b0;
      attack_valid  <= 1'b0;
      key_reject    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      attack_valid  <= 1'b0;
      key_reject    <= 1'b0;
      timeout_pulse <= 1'b0;
      if (state != IDLE && battle_end) begin
        state       <= IDLE;
        timer       <= 32'd0;
        player_turn <= 1'b0;
        enemy_turn  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (battle_start) begin
              state       <= P_SELECT;
              timer       <= 32'd0;
              player_turn <= 1'b1;
            end
          end
          P_SELECT: begin
            timer <= timer_next;
            if (make_valid && p_hit && !p_blocked) begin
              player_choice <= p_sel;
              attack_valid  <= 1'b1;
              state         <= P_RESOLVE;
            end else begin
              if (make_valid && p_hit) key_reject <= 1'b1;
              if (timeout_hit) begin
                player_choice <= PUNCH;
                attack_valid  <= 1'b1;
                timeout_pulse <= 1'b1;
                state         <= P_RESOLVE;
              end
            end
          end
          P_RESOLVE: begin
            if (collision_detected) begin
              state       <= E_SELECT;
              timer       <= 32'd0;
              player_turn <= 1'b0;
              enemy_turn  <= 1'b1;
            end
          end
          E_SELECT: begin
            timer <= timer_next;
            if (make_valid && e_hit && !e_blocked) begin
              enemy_choice <= e_sel;
              attack_valid <= 1'b1;
              state        <= E_RESOLVE;
            end else begin
              if (make_valid && e_hit) key_reject <= 1'b1;
              if (timeout_hit) begin
                enemy_choice  <= PUNCH;
                attack_valid  <= 1'b1;
                timeout_pulse <= 1'b1;
                state         <= E_RESOLVE;
              end
            end
          end
          E_RESOLVE: begin
            if (collision_detected) begin
              state       <= P_SELECT;
              timer       <= 32'd0;
              player_turn <= 1'b1;
              enemy_turn  <= 1'b0;
            end
          end
          default: begin
            state       <= IDLE;
            player_turn <= 1'b0;
            enemy_turn  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_attack_input_arbiter.sv
// Scoreboard bench for attack_input_arbiter: expected attacks are queued as keys are
// driven and matched against every attack_valid pulse the DUT produces.
module tb_attack_input_arbiter;
  import attack_input_arbiter_pkg::*;

  typedef struct packed {
    logic       p;
    logic       e;
    logic [1:0] ch;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       battle_start = 1'b0;
  logic       battle_end = 1'b0;
  logic       collision_detected = 1'b0;
  logic       player_remained_sword = 1'b1;
  logic       player_remained_baseballbat = 1'b1;
  logic       enemy_remained_sword = 1'b1;
  logic       enemy_remained_baseballbat = 1'b1;
  logic [1:0] player_choice, enemy_choice;
  logic       player_turn, enemy_turn, attack_valid, key_reject, timeout_pulse;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  attack_input_arbiter #(.TIMEOUT_CYCLES(32'd16)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .scan_code                   (scan_code),
    .scan_valid                  (scan_valid),
    .battle_start                (battle_start),
    .battle_end                  (battle_end),
    .collision_detected          (collision_detected),
    .player_remained_sword       (player_remained_sword),
    .player_remained_baseballbat (player_remained_baseballbat),
    .enemy_remained_sword        (enemy_remained_sword),
    .enemy_remained_baseballbat  (enemy_remained_baseballbat),
    .player_choice               (player_choice),
    .enemy_choice                (enemy_choice),
    .player_turn                 (player_turn),
    .enemy_turn                  (enemy_turn),
    .attack_valid                (attack_valid),
    .key_reject                  (key_reject),
    .timeout_pulse               (timeout_pulse)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1 time unit later and any attack is scored.
  task automatic tick();
    exp_t got;
    exp_t want;
    @(posedge clk);
    #1;
    vectors++;
    if (player_turn && enemy_turn) begin
      miscompares++;
      $display("[TB] FAIL turn_exclusive: got player_turn=%0b enemy_turn=%0b, need not both 1",
               player_turn, enemy_turn);
    end
    if (attack_valid) begin
      got = {player_turn, enemy_turn, (player_turn ? player_choice : enemy_choice), timeout_pulse};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL attack_unexpected: got {p,e,ch,to}=%b, none expected", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          miscompares++;
          $display("[TB] FAIL attack_match: got {p,e,ch,to}=%b, want %b", got, want);
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] code);
    scan_code  = code;
    scan_valid = 1'b1;
    tick();
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic collide();
    collision_detected = 1'b1;
    tick();
    collision_detected = 1'b0;
  endtask

  task automatic push_exp(input logic p, input logic e, input logic [1:0] ch, input logic to);
    exp_t x;
    x = {p, e, ch, to};
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    vectors++;
    if ({player_choice, enemy_choice, player_turn, enemy_turn, attack_valid, key_reject, timeout_pulse} !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b, want 0",
               {player_choice, enemy_choice, player_turn, enemy_turn, attack_valid, key_reject, timeout_pulse});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_player_punch();
    battle_start = 1'b1;
    tick();
    battle_start = 1'b0;
    vectors++;
    if ({player_turn, enemy_turn} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL start_turn: got p/e=%b, want 10", {player_turn, enemy_turn});
    end
    push_exp(1'b1, 1'b0, PUNCH, 1'b0);
    send(SCAN_PP);
    vectors++;
    if (attack_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL punch_latency: got attack_valid=%b, want 1", attack_valid);
    end
    tick();
    vectors++;
    if ({attack_valid, player_turn} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL punch_pulse: got valid/pturn=%b, want 01", {attack_valid, player_turn});
    end
    // In P_RESOLVE: a restart request and further keys must be ignored.
    battle_start = 1'b1;
    tick();
    battle_start = 1'b0;
    send(SCAN_PS);
    send(SCAN_PK);
  endtask

  task automatic test_enemy_turn();
    collide();
    vectors++;
    if ({player_turn, enemy_turn} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL enemy_turn: got p/e=%b, want 01", {player_turn, enemy_turn});
    end
    send(SCAN_PP);
    push_exp(1'b0, 1'b1, KICK, 1'b0);
    send(SCAN_EK);
    vectors++;
    if ({enemy_choice, player_choice} !== {KICK, PUNCH}) begin
      miscompares++;
      $display("[TB] FAIL enemy_kick: got e/p choice=%b, want %b", {enemy_choice, player_choice}, {KICK, PUNCH});
    end
    collide();
    collide();
    vectors++;
    if ({player_turn, enemy_turn} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL select_collision: got p/e=%b, want 10", {player_turn, enemy_turn});
    end
  endtask

  task automatic test_prefix_filter();
    send(PREFIX_BREAK);
    send(SCAN_PS);
    send(PREFIX_EXT);
    send(SCAN_PK);
    push_exp(1'b1, 1'b0, SWORD, 1'b0);
    send(SCAN_PS);
    vectors++;
    if (player_choice !== SWORD || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL prefix_sword: got choice=%b pending=%0d, want %b pending=0",
               player_choice, exp_q.size(), SWORD);
      exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    collide();
    idle(15);
    vectors++;
    if (attack_valid !== 1'b0 || enemy_turn !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_early: got valid=%b eturn=%b, want 0 1", attack_valid, enemy_turn);
    end
    push_exp(1'b0, 1'b1, PUNCH, 1'b1);
    tick();
    vectors++;
    if ({attack_valid, timeout_pulse, enemy_choice} !== {2'b11, PUNCH}) begin
      miscompares++;
      $display("[TB] FAIL timeout_fire: got valid/to/ch=%b, want 1100", {attack_valid, timeout_pulse, enemy_choice});
      exp_q.delete();
    end
  endtask

  task automatic test_key_at_timeout();
    collide();
    idle(15);
    push_exp(1'b1, 1'b0, KICK, 1'b0);
    send(SCAN_PK);
    vectors++;
    if ({attack_valid, timeout_pulse, player_choice} !== {2'b10, KICK}) begin
      miscompares++;
      $display("[TB] FAIL key_beats_timeout: got valid/to/ch=%b, want 1001", {attack_valid, timeout_pulse, player_choice});
      exp_q.delete();
    end
  endtask

  task automatic test_reject();
    collide();
    enemy_remained_sword = 1'b0;
    send(SCAN_ES);
    vectors++;
    if ({key_reject, attack_valid, enemy_turn} !== 3'b101) begin
      miscompares++;
      $display("[TB] FAIL enemy_reject: got rej/valid/eturn=%b, want 101", {key_reject, attack_valid, enemy_turn});
    end
    push_exp(1'b0, 1'b1, BAT, 1'b0);
    send(SCAN_EB);
    collide();
    player_remained_baseballbat = 1'b0;
    send(SCAN_PB);
    vectors++;
    if ({key_reject, attack_valid, player_turn} !== 3'b101) begin
      miscompares++;
      $display("[TB] FAIL player_reject: got rej/valid/pturn=%b, want 101", {key_reject, attack_valid, player_turn});
    end
    // The reject must not restart the turn timer.
    idle(14);
    push_exp(1'b1, 1'b0, PUNCH, 1'b1);
    tick();
    vectors++;
    if ({attack_valid, timeout_pulse, key_reject} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL reject_timer: got valid/to/rej=%b, want 110", {attack_valid, timeout_pulse, key_reject});
      exp_q.delete();
    end
  endtask

  task automatic test_battle_end();
    battle_end = 1'b1;
    collision_detected = 1'b1;
    tick();
    battle_end = 1'b0;
    collision_detected = 1'b0;
    vectors++;
    if ({player_turn, enemy_turn} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL battle_end: got p/e=%b, want 00", {player_turn, enemy_turn});
    end
    send(SCAN_PP);
    idle(2);
  endtask

  task automatic test_reset_mid();
    battle_start = 1'b1;
    tick();
    battle_start = 1'b0;
    push_exp(1'b1, 1'b0, PUNCH, 1'b0);
    send(SCAN_PP);
    collide();
    rst = 1'b1;
    send(SCAN_EK);
    vectors++;
    if ({player_choice, enemy_choice, player_turn, enemy_turn, attack_valid, key_reject, timeout_pulse} !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: got %b, want 0",
               {player_choice, enemy_choice, player_turn, enemy_turn, attack_valid, key_reject, timeout_pulse});
    end
    rst = 1'b0;
    idle(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending attacks, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_player_punch();
    test_enemy_turn();
    test_prefix_filter();
    test_timeout();
    test_key_at_timeout();
    test_reject();
    test_battle_end();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
